// File: rtl/time_counter.sv
// time_counter: time-of-day counter producing binary hours/minutes/seconds,
// advanced by a 1 Hz tick derived from the system clock, with a validated time-set request.
//   clk, rst_n            : system clock, asynchronous active-low reset
//   run_en                : 1 = time advances, 0 = paused
//   set_en                : one-cycle load request for set_hour/set_min/set_sec
//   hour_out/min_out/sec_out : registered binary time (0-23 / 0-59 / 0-59)
//   tick_1hz, day_wrap, set_err : registered one-cycle pulses
module time_counter #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_en,
    input  logic       set_en,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic [7:0] hour_out,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic       tick_1hz,
    output logic       day_wrap,
    output logic       set_err
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} mode_t;

    mode_t         state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic          tick_q, tick_d, wrap_q, wrap_d, err_q, err_d;
    logic          advance, set_ok;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        // The mode follows run_en on every edge; the prescaler is gated by the
        // mode being entered so run_en takes effect on the very edge it is sampled.
        if (state_q != mode_t'(run_en))
            state_d = mode_t'(run_en);
        advance = (state_d == RUN) && (pre_q == PRE_MAX);
        set_ok  = (set_hour < 8'd24) && (set_min < 8'd60) && (set_sec < 8'd60);
        if (state_d == RUN)
            pre_d = advance ? '0 : pre_q + 1'b1;
        if (advance) begin
            tick_d = 1'b1;
            sec_d  = (sec_q == 8'd59) ? 8'd0 : sec_q + 8'd1;
            if (sec_q == 8'd59) begin
                min_d = (min_q == 8'd59) ? 8'd0 : min_q + 8'd1;
                if (min_q == 8'd59) begin
                    hour_d = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
                    wrap_d = (hour_q == 8'd23);
                end
            end
        end
        // A valid set overrides a coincident advance; an invalid one only flags an error.
        if (set_en) begin
            if (set_ok) begin
                hour_d = set_hour;
                min_d  = set_min;
                sec_d  = set_sec;
                pre_d  = '0;
                tick_d = 1'b0;
                wrap_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAUSE;
            pre_q   <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign hour_out = hour_q;
    assign min_out  = min_q;
    assign sec_out  = sec_q;
    assign tick_1hz = tick_q;
    assign day_wrap = wrap_q;
    assign set_err  = err_q;
endmodule
